// File: rtl/led_matrix_scan.sv
// Row-scanned LED matrix driver with double-buffered frame memory and blanking gaps.
// Define LED_MATRIX_SCAN_DIM_EN to add the brightness input and 16-step PWM dimming.
module led_matrix_scan #(
    parameter int ROWS   = 9,
    parameter int COLS   = 8,
    parameter int PERIOD = 27000,
    parameter int GAP    = 500,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap_req,
`ifdef LED_MATRIX_SCAN_DIM_EN
    input  logic [3:0]      brightness,
`endif
    output logic            swap_done,
    output logic            frame_start,
    output logic [COLS-1:0] led_col,
    output logic [ROWS-1:0] led_row
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
    localparam logic [CW-1:0] WIN_LO  = CW'(GAP);
    localparam logic [CW-1:0] WIN_HI  = CW'(PERIOD - GAP);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [RW:0]   ROWS_W  = (RW + 1)'(ROWS);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic            front_sel_q;
    logic            pend_q;
    logic [COLS-1:0] buf_q [2][ROWS];
    logic [ROWS-1:0] led_row_q;
    logic [COLS-1:0] led_col_q, col_d;
    logic            swap_done_q, frame_start_q;
    logic            boundary, active, swap_now, wr_ok;

`ifdef LED_MATRIX_SCAN_DIM_EN
    logic [3:0] pwm_q, pwm_cur;
    logic [3:0] bright_q;
`endif

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        row_d = row_q;
        if (cnt_q == CNT_MAX)
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
    end

    assign boundary = (cnt_q == CNT_MAX) && (row_q == ROW_MAX);
    assign active   = (cnt_q >= WIN_LO) && (cnt_q < WIN_HI);
    // A request arriving on the boundary cycle itself is honoured at that boundary.
    assign swap_now = boundary && (pend_q || swap_req);
    assign wr_ok    = wr_en && ({1'b0, wr_row} < ROWS_W);

    always_comb begin
        col_d = buf_q[front_sel_q][row_q];
`ifdef LED_MATRIX_SCAN_DIM_EN
        pwm_cur = (cnt_q == WIN_LO) ? 4'd0 : pwm_q;
        if (pwm_cur > bright_q)
            col_d = '0;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q         <= '0;
            row_q         <= '0;
            front_sel_q   <= 1'b0;
            pend_q        <= 1'b0;
            led_row_q     <= '0;
            led_col_q     <= '0;
            swap_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                buf_q[0][r] <= '0;
                buf_q[1][r] <= '0;
            end
`ifdef LED_MATRIX_SCAN_DIM_EN
            pwm_q    <= '0;
            bright_q <= 4'hF;
`endif
        end else begin
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            led_row_q     <= active ? (ROWS'(1) << row_q) : '0;
            led_col_q     <= active ? col_d : '0;
            frame_start_q <= boundary;
            swap_done_q   <= swap_now;
            if (swap_now) begin
                front_sel_q <= ~front_sel_q;
                pend_q      <= 1'b0;
            end else if (swap_req) begin
                pend_q <= 1'b1;
            end
            // Uses the pre-swap select, so a write coincident with a swap lands in the new front.
            if (wr_ok)
                buf_q[~front_sel_q][wr_row] <= wr_data;
`ifdef LED_MATRIX_SCAN_DIM_EN
            if (active)
                pwm_q <= pwm_cur + 4'd1;
            if (boundary)
                bright_q <= brightness;
`endif
        end
    end

    // Registered pulses appear in the cycle following the boundary edge.
    assign swap_done   = swap_done_q;
    assign frame_start = frame_start_q;
    assign led_col     = led_col_q;
    assign led_row     = led_row_q;
endmodule

// File: tb/tb_led_matrix_scan.sv
// Randomized bench for led_matrix_scan against a cycle-index reference model.
module tb_led_matrix_scan;
    localparam int ROWS = 3, COLS = 4, PERIOD = 10, GAP = 2;
    localparam int RW = $clog2(ROWS);

    logic            sys_clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic [RW-1:0]   wr_row = '0;
    logic [COLS-1:0] wr_data = '0;
    logic            swap_req = 1'b0;
    logic [3:0]      brightness = 4'hF;
    logic            swap_done, frame_start;
    logic [COLS-1:0] led_col;
    logic [ROWS-1:0] led_row;

    led_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .PERIOD(PERIOD), .GAP(GAP)) dut (
        .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .swap_req(swap_req),
`ifdef LED_MATRIX_SCAN_DIM_EN
        .brightness(brightness),
`endif
        .swap_done(swap_done), .frame_start(frame_start), .led_col(led_col), .led_row(led_row)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0, n_err = 0;
    int n_sd = 0, n_fs = 0;

    // Reference state: absolute cycle index since reset plus two plain row arrays.
    int unsigned     m_cyc = 0;
    logic [COLS-1:0] m_front [ROWS];
    logic [COLS-1:0] m_back  [ROWS];
    logic            m_pend = 1'b0;
    logic [3:0]      m_bright = 4'hF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        int cnt, row;
        bit act, bnd;
        logic [ROWS-1:0] one;
        logic [ROWS-1:0] e_row;
        logic [COLS-1:0] e_col, tmp;
        logic e_fs, e_sd;
        one = 1;
        e_row = '0; e_col = '0; e_fs = 1'b0; e_sd = 1'b0; bnd = 1'b0;
        cnt = int'(m_cyc % PERIOD);
        row = int'((m_cyc / PERIOD) % ROWS);
        if (!rst) begin
            act = (cnt >= GAP) && (cnt < PERIOD - GAP);
            bnd = (cnt == PERIOD - 1) && (row == ROWS - 1);
            if (act) begin
                e_row = one << row;
                e_col = m_front[row];
`ifdef LED_MATRIX_SCAN_DIM_EN
                if (((cnt - GAP) % 16) > int'(m_bright)) e_col = '0;
`endif
            end
            e_fs = bnd;
            e_sd = bnd && (m_pend || swap_req);
        end
        @(posedge sys_clk);
        if (rst) begin
            m_cyc = 0; m_pend = 1'b0; m_bright = 4'hF;
            for (int r = 0; r < ROWS; r++) begin m_front[r] = '0; m_back[r] = '0; end
        end else begin
            if (wr_en && int'(wr_row) < ROWS) m_back[wr_row] = wr_data;
            if (e_sd) begin
                for (int r = 0; r < ROWS; r++) begin
                    tmp = m_front[r]; m_front[r] = m_back[r]; m_back[r] = tmp;
                end
                m_pend = 1'b0;
            end else if (swap_req) m_pend = 1'b1;
            if (bnd) m_bright = brightness;
            m_cyc++;
        end
        #1;
        chk("led_row", 32'(led_row), 32'(e_row));
        chk("led_col", 32'(led_col), 32'(e_col));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("swap_done", 32'(swap_done), 32'(e_sd));
        n_sd += int'(swap_done);
        n_fs += int'(frame_start);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [RW-1:0] r, input logic [COLS-1:0] d);
        wr_en = 1'b1; wr_row = r; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    // Advance to the cycle where the scan sits at (row, cnt); bounded to two frames.
    task automatic goto_pos(input int row, input int cnt);
        int k;
        k = 0;
        while (!((m_cyc % PERIOD) == cnt && ((m_cyc / PERIOD) % ROWS) == row) && k < 2 * ROWS * PERIOD) begin
            tick();
            k++;
        end
    endtask

    initial begin
        run(3);
        rst = 1'b0;
        chk("reset_row", 32'(led_row), 32'd0);
        chk("reset_col", 32'(led_col), 32'd0);

        // Idle: three blank frames, one frame_start per frame.
        n_fs = 0;
        run(3 * ROWS * PERIOD);
        chk("idle_fs_count", 32'(n_fs), 32'd3);

        // Load A/5/F and swap at the next boundary.
        wr(2'd0, 4'hA); wr(2'd1, 4'h5); wr(2'd2, 4'hF);
        n_sd = 0;
        pulse_swap();
        run(2 * ROWS * PERIOD);
        chk("swap1_count", 32'(n_sd), 32'd1);

        // Mid-frame write to back buffer must not show until another swap.
        goto_pos(1, 4);
        wr(2'd1, 4'h3);
        run(2 * ROWS * PERIOD);
        goto_pos(1, 5);
        chk("row1_held", 32'(led_col), 32'h5);

        // Double request in a frame plus an out-of-range row write.
        goto_pos(0, 1);
        n_sd = 0;
        pulse_swap();
        run(5);
        pulse_swap();
        wr(2'd3, 4'hC);
        goto_pos(0, 0);
        run(ROWS * PERIOD);
        chk("swap2_count", 32'(n_sd), 32'd1);

        // Reset with a swap pending at row 1, cnt 5.
        goto_pos(0, 3);
        n_sd = 0;
        pulse_swap();
        goto_pos(1, 5);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk("rst_row", 32'(led_row), 32'd0);
        run(2 * ROWS * PERIOD);
        chk("rst_swap_count", 32'(n_sd), 32'd0);

`ifdef LED_MATRIX_SCAN_DIM_EN
        wr(2'd0, 4'hF); wr(2'd1, 4'hF); wr(2'd2, 4'hF);
        brightness = 4'd3;
        pulse_swap();
        run(3 * ROWS * PERIOD);
        brightness = 4'hF;
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_row     = RW'($urandom_range(0, (1 << RW) - 1));
            wr_data    = COLS'($urandom);
            swap_req   = ($urandom_range(0, 24) == 0);
            brightness = 4'($urandom);
            tick();
        end
        rst = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
